// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared state encoding and round-robin pick helper for the vram write arbiter
package vram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MAX_NR = 16;

  // First set bit of valid searching upward from ptr+1 (mod nr); returns ptr when nothing is valid.
  // The loop walks from farthest to nearest so the nearest candidate is written last and wins.
  function automatic logic [3:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr, input int nr);
    int idx;
    rr_pick = ptr;
    for (int k = MAX_NR; k >= 1; k--) begin
      if (k <= nr) begin
        idx = (int'(ptr) + k) % nr;
        if (valid[idx[3:0]]) rr_pick = idx[3:0];
      end
    end
  endfunction

endpackage

// File: rtl/vram_wr_arbiter_rr_arbiter.sv
// rtl/vram_wr_arbiter_rr_arbiter.sv - NR-wide round-robin grant with its pointer register
module rr_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NR = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic [NR-1:0]         valid,
  output logic [$clog2(NR)-1:0] grant,
  output logic                  any
);

  localparam int PW = $clog2(NR);

  logic [PW-1:0] ptr;

  // Grant is purely combinational from the current pointer and the valid vector.
  always_comb begin
    grant = PW'(rr_pick(16'(valid), 4'(ptr), NR));
    any   = |valid;
  end

  // Pointer moves to the last granted engine only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= PW'(NR - 1);
    else if (advance) ptr <= grant;
  end

endmodule

// File: rtl/vram_wr_arbiter.sv
// rtl/vram_wr_arbiter.sv - frame sequencer sharing the vram write port among NR engines; VRAM_WR_ARB_STATS_EN adds stall_cnt
module vram_wr_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NR   = 4,
  parameter int IMAW = 19,
  parameter int IMDW = 8,
  parameter int IMD  = 480000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic                 clear_en,
  input  logic [IMDW-1:0]      fill_dat,
  input  logic [NR-1:0]        req_valid,
  output logic [NR-1:0]        req_ready,
  input  logic [NR*IMAW-1:0]   req_adr,
  input  logic [NR*IMDW-1:0]   req_dat,
  output logic                 vram_we,
  output logic [IMAW-1:0]      vram_adr_w,
  output logic [IMDW-1:0]      vram_dat_w,
  output logic                 busy,
  output logic                 done,
  output logic                 adr_err,
  output logic [IMAW-1:0]      pix_cnt
`ifdef VRAM_WR_ARB_STATS_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int            PW       = $clog2(NR);
  localparam logic [IMAW:0] IMD_W    = (IMAW + 1)'(IMD);
  localparam logic [IMAW-1:0] LAST_ADR = IMAW'(IMD - 1);

  if (IMD < 1 || IMD > 2 ** IMAW || NR < 2 || NR > MAX_NR) begin : g_param_check
    $error("vram_wr_arbiter: bad NR/IMD/IMAW combination");
  end

  state_t          state, nxt_state;
  logic [PW-1:0]   grant;
  logic            any, hs, start_frame;
  logic [IMAW-1:0] g_adr, clr_adr, nxt_clr_adr, nxt_adr, nxt_pix;
  logic [IMDW-1:0] g_dat, fill_q, nxt_fill, nxt_dat;
  logic            nxt_we, nxt_err;

  rr_arbiter #(.NR(NR)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (hs),
    .valid   (req_valid),
    .grant   (grant),
    .any     (any)
  );

  // Handshake qualifiers and the single ready bit for the granted engine.
  always_comb begin
    hs          = (state == ST_RUN) && clk_en && any;
    start_frame = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    g_adr       = req_adr[int'(grant) * IMAW +: IMAW];
    g_dat       = req_dat[int'(grant) * IMDW +: IMDW];
    req_ready   = '0;
    if (hs) req_ready[grant] = 1'b1;
  end

  // Next state and next values of the write register and frame counters.
  always_comb begin
    nxt_state   = state;
    nxt_we      = 1'b0;
    nxt_adr     = vram_adr_w;
    nxt_dat     = vram_dat_w;
    nxt_pix     = pix_cnt;
    nxt_err     = adr_err;
    nxt_clr_adr = clr_adr;
    nxt_fill    = fill_q;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          nxt_state   = clear_en ? ST_CLEAR : ST_RUN;
          nxt_pix     = '0;
          nxt_err     = 1'b0;
          nxt_clr_adr = '0;
          nxt_fill    = fill_dat;
        end
      end
      ST_CLEAR: begin
        nxt_we  = 1'b1;
        nxt_adr = clr_adr;
        nxt_dat = fill_q;
        if (clr_adr == LAST_ADR) begin
          nxt_state   = ST_RUN;
          nxt_pix     = '0;
          nxt_clr_adr = '0;
        end else begin
          nxt_clr_adr = clr_adr + 1'b1;
        end
      end
      ST_RUN: begin
        if (hs) begin
          if ({1'b0, g_adr} < IMD_W) begin
            nxt_we  = 1'b1;
            nxt_adr = g_adr;
            nxt_dat = g_dat;
            nxt_pix = pix_cnt + 1'b1;
            if (({1'b0, pix_cnt} + 1'b1) == IMD_W) nxt_state = ST_DONE;
          end else begin
            nxt_err = 1'b1;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // State, write port and status registers; everything holds while clk_en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vram_we    <= 1'b0;
      vram_adr_w <= '0;
      vram_dat_w <= '0;
      pix_cnt    <= '0;
      adr_err    <= 1'b0;
      clr_adr    <= '0;
      fill_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (clk_en) begin
      state      <= nxt_state;
      vram_we    <= nxt_we;
      vram_adr_w <= nxt_adr;
      vram_dat_w <= nxt_dat;
      pix_cnt    <= nxt_pix;
      adr_err    <= nxt_err;
      clr_adr    <= nxt_clr_adr;
      fill_q     <= nxt_fill;
      busy       <= (nxt_state == ST_CLEAR) || (nxt_state == ST_RUN);
      done       <= (nxt_state == ST_DONE);
    end
  end

`ifdef VRAM_WR_ARB_STATS_EN
  logic [32:0] stall_sum;

  // Every valid engine that lost this cycle's grant adds one stall.
  always_comb begin
    stall_sum = {1'b0, stall_cnt} + 33'($countones(req_valid)) - 33'd1;
  end

  // Saturating stall counter, cleared at each frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt <= '0;
    else if (clk_en) begin
      if (start_frame) stall_cnt <= '0;
      else if (hs) stall_cnt <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// tb/tb_vram_wr_arbiter.sv - directed self-checking bench for vram_wr_arbiter
module tb_vram_wr_arbiter;

  localparam int NR   = 4;
  localparam int IMAW = 5;
  localparam int IMDW = 8;
  localparam int IMD  = 16;

  logic              clk = 1'b0;
  logic              rst_n, clk_en, start, clear_en;
  logic [IMDW-1:0]   fill_dat;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*IMAW-1:0] req_adr;
  logic [NR*IMDW-1:0] req_dat;
  logic              vram_we, busy, done, adr_err;
  logic [IMAW-1:0]   vram_adr_w, pix_cnt;
  logic [IMDW-1:0]   vram_dat_w;
`ifdef VRAM_WR_ARB_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  vram_wr_arbiter #(.NR(NR), .IMAW(IMAW), .IMDW(IMDW), .IMD(IMD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .start      (start),
    .clear_en   (clear_en),
    .fill_dat   (fill_dat),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_adr    (req_adr),
    .req_dat    (req_dat),
    .vram_we    (vram_we),
    .vram_adr_w (vram_adr_w),
    .vram_dat_w (vram_dat_w),
    .busy       (busy),
    .done       (done),
    .adr_err    (adr_err),
    .pix_cnt    (pix_cnt)
`ifdef VRAM_WR_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every engine presents the same address; data is 0x10 + engine index.
  task automatic set_req(input logic [NR-1:0] mask, input int adr);
    req_valid = mask;
    for (int i = 0; i < NR; i++) begin
      req_adr[i*IMAW +: IMAW] = IMAW'(adr);
      req_dat[i*IMDW +: IMDW] = IMDW'(8'h10 + i);
    end
  endtask

  typedef struct { logic [3:0] mask; int g; } step_t;
  step_t t3 [7];

  initial begin
    t3[0] = '{4'b1010, 1}; t3[1] = '{4'b1010, 3}; t3[2] = '{4'b1010, 1};
    t3[3] = '{4'b1010, 3}; t3[4] = '{4'b1011, 0}; t3[5] = '{4'b1011, 1};
    t3[6] = '{4'b1011, 3};

    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; clear_en = 1'b0; fill_dat = '0;
    set_req(4'b0000, 0);
    tick(); tick();
    chk("rst_we", vram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix", pix_cnt, 0);
    chk("rst_err", adr_err, 0);
    chk("rst_ready", req_ready, 0);

    // clear pass; fill value changed after entry must not leak in
    rst_n = 1'b1; start = 1'b1; clear_en = 1'b1; fill_dat = 8'h00;
    tick();
    start = 1'b0; fill_dat = 8'hAA;
    chk("clr_busy", busy, 1);
    chk("clr_we0", vram_we, 0);
    for (int i = 0; i < IMD; i++) begin
      tick();
      chk("clr_we", vram_we, 1);
      chk("clr_adr", vram_adr_w, i);
      chk("clr_dat", vram_dat_w, 8'h00);
    end
    chk("run_busy", busy, 1);
    chk("run_pix0", pix_cnt, 0);
    chk("run_done0", done, 0);

    // all four engines valid: 0,1,2,3 repeating
    for (int n = 0; n < IMD; n++) begin
      set_req(4'b1111, n);
      #1;
      chk("t2_ready", req_ready, 4'b0001 << (n % 4));
      tick();
      chk("t2_we", vram_we, 1);
      chk("t2_adr", vram_adr_w, n);
      chk("t2_dat", vram_dat_w, 8'h10 + (n % 4));
      chk("t2_pix", pix_cnt, n + 1);
      chk("t2_done", done, (n == IMD - 1) ? 1 : 0);
    end
    chk("t2_busy", busy, 0);
    chk("t2_ready_done", req_ready, 0);

    // new frame without clear; engines 1 and 3, then 0 joins
    start = 1'b1; clear_en = 1'b0; set_req(4'b0000, 0);
    tick();
    start = 1'b0;
    chk("t3_done", done, 0);
    chk("t3_busy", busy, 1);
    chk("t3_pix", pix_cnt, 0);
    for (int k = 0; k < 7; k++) begin
      set_req(t3[k].mask, k);
      #1;
      chk("t3_ready", req_ready, 4'b0001 << t3[k].g);
      tick();
      chk("t3_adr", vram_adr_w, k);
      chk("t3_dat", vram_dat_w, 8'h10 + t3[k].g);
      chk("t3_pix", pix_cnt, k + 1);
    end

    // out-of-range address from engine 2
    set_req(4'b0100, IMD + 5);
    #1;
    chk("t4_ready", req_ready, 4'b0100);
    tick();
    chk("t4_we", vram_we, 0);
    chk("t4_pix", pix_cnt, 7);
    chk("t4_err", adr_err, 1);

    // clk_en 1,0 pattern; pointer now 2 so grants run 3,0,1,2,...
    for (int j = 0; j < 9; j++) begin
      clk_en = 1'b1;
      set_req(4'b1111, 7 + j);
      #1;
      chk("t5_ready", req_ready, 4'b0001 << ((3 + j) % 4));
      tick();
      chk("t5_we", vram_we, 1);
      chk("t5_adr", vram_adr_w, 7 + j);
      chk("t5_dat", vram_dat_w, 8'h10 + ((3 + j) % 4));
      chk("t5_pix", pix_cnt, 8 + j);
      if (j < 8) begin
        clk_en = 1'b0;
        #1;
        chk("t5_ready_off", req_ready, 0);
        tick();
        chk("t5_pix_hold", pix_cnt, 8 + j);
        chk("t5_we_hold", vram_we, 1);
        chk("t5_adr_hold", vram_adr_w, 7 + j);
      end
    end
    clk_en = 1'b1;
    chk("t5_done", done, 1);
    chk("t5_err_sticky", adr_err, 1);

    // new frame clears adr_err; run to pix_cnt=7 then reset
    start = 1'b1; clear_en = 1'b0; set_req(4'b0000, 0);
    tick();
    start = 1'b0;
    chk("t6_err_clr", adr_err, 0);
    chk("t6_pix0", pix_cnt, 0);
    for (int j = 0; j < 7; j++) begin
      set_req(4'b1111, j);
      #1;
      chk("t6_ready", req_ready, 4'b0001 << (j % 4));
      tick();
    end
    chk("t6_pix7", pix_cnt, 7);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_we", vram_we, 0);
    chk("t6_rst_pix", pix_cnt, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", req_ready, 0);
    rst_n = 1'b1; start = 1'b1; set_req(4'b0000, 0);
    tick();
    start = 1'b0;
    chk("t6_busy", busy, 1);
    set_req(4'b1111, 9);
    #1;
    chk("t6_ready_new", req_ready, 4'b0001);
    tick();
    chk("t6_we", vram_we, 1);
    chk("t6_adr", vram_adr_w, 9);
    chk("t6_dat", vram_dat_w, 8'h10);
    chk("t6_pix1", pix_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
